// File: rtl/cp0_unit_pkg.sv
// cp0_unit_pkg: shared constants for the coprocessor-0 slice.
//   - CP0 register numbers (SR, Cause, EPC, PRId)
//   - SR / Cause bit-field positions
//   - exception codes
//   - the exception handler entry address
//   - the helper that forms the EPC value for a trapping instruction
package cp0_unit_pkg;

  localparam logic [4:0] REG_SR    = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC   = 5'd14;
  localparam logic [4:0] REG_PRID  = 5'd15;

  localparam int SR_IE      = 0;
  localparam int SR_EXL     = 1;
  localparam int SR_IM_LO   = 10;
  localparam int SR_IM_HI   = 15;
  localparam int CAUSE_EXC_LO = 2;
  localparam int CAUSE_EXC_HI = 6;
  localparam int CAUSE_IP_LO  = 10;
  localparam int CAUSE_IP_HI  = 15;
  localparam int CAUSE_BD     = 31;

  typedef enum logic [4:0] {
    EXC_INT  = 5'd0,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_RI   = 5'd10,
    EXC_OV   = 5'd12
  } exc_code_e;

  localparam logic [31:0] HANDLER_PC_DEFAULT = 32'h0000_4180;

  // A delay-slot instruction restarts at its branch, one word earlier.
  function automatic logic [31:0] trap_epc(input logic [31:0] pc, input logic bd);
    logic [31:0] pc_adj;
    pc_adj = bd ? (pc - 32'd4) : pc;
    return pc_adj & ~32'd3;
  endfunction

endpackage

// File: rtl/cp0_unit_if.sv
// cp0_unit_if: M-stage traffic between the pipeline and coprocessor 0.
//   we/reg_addr/wdata/rdata : mtc0 write and mfc0 read
//   pc_m/bd_m/exc_code_m    : faulting-instruction context
//   eret_m                  : eret in M
//   req/epc_out             : exception request and EPC to next-PC logic
//   handler_pc              : exported handler entry address
// master = pipeline side, slave = cp0_unit.
interface cp0_unit_if;
  logic        we;
  logic [4:0]  reg_addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [31:0] pc_m;
  logic        bd_m;
  logic [4:0]  exc_code_m;
  logic        eret_m;
  logic        req;
  logic [31:0] epc_out;
  logic [31:0] handler_pc;

  modport master (
    output we, reg_addr, wdata, pc_m, bd_m, exc_code_m, eret_m,
    input  rdata, req, epc_out, handler_pc
  );

  modport slave (
    input  we, reg_addr, wdata, pc_m, bd_m, exc_code_m, eret_m,
    output rdata, req, epc_out, handler_pc
  );
endinterface

// File: rtl/cp0_unit.sv
// cp0_unit: coprocessor 0 for the pipelined MIPS core.
// Detects interrupts and M-stage exceptions, records EPC/Cause/SR, and
// returns the request and EPC consumed by D-stage next-PC logic.
// Ports:
//   clk      core clock
//   reset_n  asynchronous active-low reset
//   bus      cp0_unit_if.slave (mtc0/mfc0, M-stage context, req/epc_out)
//   hw_int   level-sensitive external interrupt lines
//   exl      SR.EXL for observation
module cp0_unit
  import cp0_unit_pkg::*;
#(
  parameter logic [31:0] PRID_VALUE = 32'h2021_0701,
  parameter logic [31:0] HANDLER_PC = HANDLER_PC_DEFAULT
) (
  input  logic             clk,
  input  logic             reset_n,
  cp0_unit_if.slave        bus,
  input  logic [5:0]       hw_int,
  output logic             exl
);

  logic [5:0]  sr_im;
  logic        sr_exl;
  logic        sr_ie;
  logic        cause_bd;
  logic [5:0]  cause_ip;
  logic [4:0]  cause_exc;
  logic [31:0] epc;

  logic        int_req;
  logic        exc_req;
  logic        req;
  logic [4:0]  exc_sel;
  logic        mtc0_sr;
  logic        mtc0_epc;

  assign int_req = (|(hw_int & sr_im)) & sr_ie & ~sr_exl;
  assign exc_req = (bus.exc_code_m != 5'd0) & ~sr_exl;
  assign req     = int_req | exc_req;
  // Interrupt wins over a simultaneous synchronous exception.
  assign exc_sel = int_req ? EXC_INT : bus.exc_code_m;

  // A trapping instruction is cancelled, so its mtc0 must not land.
  assign mtc0_sr  = bus.we & ~req & (bus.reg_addr == REG_SR);
  assign mtc0_epc = bus.we & ~req & (bus.reg_addr == REG_EPC);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sr_im     <= '0;
      sr_exl    <= 1'b0;
      sr_ie     <= 1'b0;
      cause_bd  <= 1'b0;
      cause_ip  <= '0;
      cause_exc <= '0;
      epc       <= '0;
    end else begin
      cause_ip <= hw_int;
      if (req) begin
        sr_exl    <= 1'b1;
        cause_bd  <= bus.bd_m;
        cause_exc <= exc_sel;
        epc       <= trap_epc(bus.pc_m, bus.bd_m);
      end else begin
        if (bus.eret_m) sr_exl <= 1'b0;
        if (mtc0_sr) begin
          sr_im  <= bus.wdata[SR_IM_HI:SR_IM_LO];
          sr_exl <= bus.wdata[SR_EXL];
          sr_ie  <= bus.wdata[SR_IE];
        end
        if (mtc0_epc) epc <= bus.wdata;
      end
    end
  end

  always_comb begin
    bus.rdata = '0;
    case (bus.reg_addr)
      REG_SR: begin
        bus.rdata[SR_IM_HI:SR_IM_LO] = sr_im;
        bus.rdata[SR_EXL]            = sr_exl;
        bus.rdata[SR_IE]             = sr_ie;
      end
      REG_CAUSE: begin
        bus.rdata[CAUSE_BD]                   = cause_bd;
        bus.rdata[CAUSE_IP_HI:CAUSE_IP_LO]    = cause_ip;
        bus.rdata[CAUSE_EXC_HI:CAUSE_EXC_LO]  = cause_exc;
      end
      REG_EPC:  bus.rdata = epc;
      REG_PRID: bus.rdata = PRID_VALUE;
      default:  bus.rdata = '0;
    endcase
  end

  // Same-cycle EPC forwarding lets mtc0 EPC be followed directly by eret.
  assign bus.epc_out    = mtc0_epc ? bus.wdata : epc;
  assign bus.req        = req;
  assign bus.handler_pc = HANDLER_PC;
  assign exl            = sr_exl;

endmodule

// File: tb/tb_cp0_unit.sv
// tb_cp0_unit: bench for cp0_unit. A word-level model of SR/Cause/EPC is
// updated at each clock edge from the architectural rules; a compare process
// checks req, epc_out, exl and rdata against it on every falling edge.
// Directed sections pin the model with hand-computed literal values, then
// randomized M-stage traffic runs against the model.
module tb_cp0_unit;
  import cp0_unit_pkg::*;

  localparam logic [31:0] PRID = 32'h2021_0701;
  localparam logic [31:0] HPC  = 32'h0000_4180;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [5:0] hw_int;
  logic       exl;

  cp0_unit_if bus ();

  cp0_unit #(.PRID_VALUE(PRID), .HANDLER_PC(HPC)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave),
    .hw_int  (hw_int),
    .exl     (exl)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else
      n_pass++;
  endtask

  // ---------------- behavioural model (whole-register words) ----------------
  logic [31:0] m_sr = '0;
  logic [31:0] m_cause = '0;
  logic [31:0] m_epc = '0;
  logic [31:0] m_nc;
  logic        m_r;

  function automatic logic m_int();
    return ((hw_int & m_sr[15:10]) != 6'd0) && m_sr[0] && !m_sr[1];
  endfunction

  function automatic logic m_req();
    return m_int() || ((bus.exc_code_m != 5'd0) && !m_sr[1]);
  endfunction

  function automatic logic [31:0] m_rdata(input logic [4:0] a);
    case (a)
      5'd12:   return m_sr & 32'h0000_FC03;
      5'd13:   return m_cause & 32'h8000_FC7C;
      5'd14:   return m_epc;
      5'd15:   return PRID;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] m_epc_out();
    if (bus.we && bus.reg_addr == 5'd14 && !m_req()) return bus.wdata;
    return m_epc;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_sr    = '0;
      m_cause = '0;
      m_epc   = '0;
    end else begin
      m_r  = m_req();
      m_nc = (m_cause & ~32'h0000_FC00) | (32'(hw_int) << 10);
      if (m_r) begin
        m_nc  = (m_nc & ~32'h8000_007C) | (32'(bus.bd_m) << 31)
              | ((m_int() ? 32'd0 : 32'(bus.exc_code_m)) << 2);
        m_sr  = m_sr | 32'h2;
        m_epc = (bus.bd_m ? bus.pc_m - 32'd4 : bus.pc_m) & 32'hFFFF_FFFC;
      end else begin
        if (bus.eret_m) m_sr = m_sr & ~32'h2;
        if (bus.we && bus.reg_addr == 5'd12) m_sr = bus.wdata & 32'h0000_FC03;
        if (bus.we && bus.reg_addr == 5'd14) m_epc = bus.wdata;
      end
      m_cause = m_nc;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("req", 32'(bus.req), 32'(m_req()));
      check("epc_out", bus.epc_out, m_epc_out());
      check("exl", 32'(exl), 32'(m_sr[1]));
      check("rdata", bus.rdata, m_rdata(bus.reg_addr));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.we = 1'b0; bus.reg_addr = 5'd0; bus.wdata = '0;
    bus.pc_m = '0; bus.bd_m = 1'b0; bus.exc_code_m = 5'd0; bus.eret_m = 1'b0;
    hw_int = '0;
  endtask

  logic [4:0] codes [4] = '{5'd4, 5'd5, 5'd10, 5'd12};

  initial begin
    reset_n = 1'b0;
    idle();
    chk_en = 1'b1;

    // Reset state
    for (int a = 12; a <= 15; a++) begin
      step();
      bus.reg_addr = 5'(a);
      #1;
      check("reset_rdata", bus.rdata, (a == 15) ? PRID : 32'h0);
    end
    check("reset_req", 32'(bus.req), 32'h0);
    check("reset_epc_out", bus.epc_out, 32'h0);
    check("handler_pc", bus.handler_pc, HPC);

    // Interrupt
    step(); reset_n = 1'b1; bus.we = 1'b1; bus.reg_addr = 5'd12; bus.wdata = 32'h0000_0401;
    step(); bus.we = 1'b0; hw_int = 6'b000001; bus.pc_m = 32'h3010; bus.bd_m = 1'b0;
    #1; check("int_req", 32'(bus.req), 32'h1);
    step(); bus.pc_m = 32'h3040; bus.reg_addr = 5'd14;
    #1; check("int_epc", bus.rdata, 32'h3010);
    bus.reg_addr = 5'd13;
    #1; check("int_cause", bus.rdata, 32'h0000_0400);
    check("int_exl", 32'(exl), 32'h1);
    check("int_masked_req", 32'(bus.req), 32'h0);

    // eret with interrupt still pending
    step(); bus.eret_m = 1'b1;
    #1; check("eret_req", 32'(bus.req), 32'h0);
    step(); bus.eret_m = 1'b0;
    #1; check("eret_exl", 32'(exl), 32'h0);
    check("pending_req", 32'(bus.req), 32'h1);
    step(); hw_int = '0;
    #1; check("pending_exl", 32'(exl), 32'h1);
    check("pending_epc", bus.epc_out, 32'h3040);

    // Delay-slot overflow with a dropped mtc0 EPC
    step(); bus.eret_m = 1'b1;
    step(); bus.eret_m = 1'b0; bus.exc_code_m = 5'd12; bus.pc_m = 32'h3024; bus.bd_m = 1'b1;
    bus.we = 1'b1; bus.reg_addr = 5'd14; bus.wdata = 32'hDEAD_BEEF;
    #1; check("ov_req", 32'(bus.req), 32'h1);
    check("ov_no_fwd", bus.epc_out, 32'h3040);
    step(); bus.we = 1'b0; bus.exc_code_m = 5'd0; bus.bd_m = 1'b0;
    #1; check("ov_epc", bus.rdata, 32'h3020);
    bus.reg_addr = 5'd13;
    #1; check("ov_cause", bus.rdata, 32'h8000_0030);
    check("ov_exl", 32'(exl), 32'h1);
    step(); bus.exc_code_m = 5'd4;
    #1; check("exl_masks_exc", 32'(bus.req), 32'h0);
    step(); bus.exc_code_m = 5'd0;
    #1; check("masked_cause", bus.rdata, 32'h8000_0030);

    // EPC forwarding
    step(); bus.eret_m = 1'b1;
    step(); bus.eret_m = 1'b0; bus.we = 1'b1; bus.reg_addr = 5'd14; bus.wdata = 32'h3100;
    #1; check("fwd_epc_out", bus.epc_out, 32'h3100);
    check("fwd_req", 32'(bus.req), 32'h0);
    step(); bus.we = 1'b0;
    #1; check("fwd_epc_reg", bus.rdata, 32'h3100);

    // Simultaneous interrupt, exception and eret
    step(); hw_int = 6'b000001; bus.exc_code_m = 5'd4; bus.eret_m = 1'b1; bus.pc_m = 32'h3050;
    #1; check("both_req", 32'(bus.req), 32'h1);
    step(); bus.exc_code_m = 5'd0; bus.eret_m = 1'b0; bus.reg_addr = 5'd13;
    #1; check("both_cause", bus.rdata, 32'h0000_0400);
    check("both_exl", 32'(exl), 32'h1);
    bus.reg_addr = 5'd14;
    #1; check("both_epc", bus.rdata, 32'h3050);

    // Reset in the middle of an exception
    step(); reset_n = 1'b0;
    #1; check("rst_exl", 32'(exl), 32'h0);
    check("rst_req", 32'(bus.req), 32'h0);
    step(); reset_n = 1'b1; idle();

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      step();
      bus.we = ($urandom_range(3) == 0);
      case ($urandom_range(4))
        0:       bus.reg_addr = 5'd12;
        1:       bus.reg_addr = 5'd13;
        2:       bus.reg_addr = 5'd14;
        3:       bus.reg_addr = 5'd15;
        default: bus.reg_addr = 5'($urandom_range(31));
      endcase
      bus.wdata      = $urandom;
      bus.pc_m       = $urandom;
      bus.bd_m       = 1'($urandom_range(1));
      bus.exc_code_m = ($urandom_range(7) == 0) ? codes[$urandom_range(3)] : 5'd0;
      hw_int         = ($urandom_range(1) == 0) ? 6'($urandom) : 6'd0;
      bus.eret_m     = ($urandom_range(7) == 0) && !(bus.we && bus.reg_addr == 5'd12);
    end

    step(); idle();
    step();
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cp0_unit.md
Name: cp0_unit

Overview:
Coprocessor-0 for the pipelined MIPS core. It is the responder side of the next-PC exception interface: it detects interrupts and exceptions at the M stage, records EPC/Cause/SR, and drives the Interrupt request and EPC value consumed by D-stage next-PC logic. It also services eret and mfc0/mtc0 traffic from the M stage.

Parameters:
PRID_VALUE, 32'h2021_0701, read-only processor ID returned for register 15.
HANDLER_PC, 32'h0000_4180, exception entry address; exported for consistency checks only.

Ports:
clk  in  1  core clock
reset_n  in  1  asynchronous active-low reset
we  in  1  mtc0 write enable (M stage)
reg_addr  in  5  CP0 register number for mfc0/mtc0
wdata  in  32  mtc0 write data
rdata  out  32  mfc0 read data (combinational)
pc_m  in  32  PC of instruction currently in M stage
bd_m  in  1  M instruction sits in a branch delay slot
exc_code_m  in  5  synchronous exception code from M; 0 = none
hw_int  in  6  external interrupt lines, level-sensitive
eret_m  in  1  eret in M stage
req  out  1  take exception/interrupt this cycle (to next-PC Interrupt, pipeline flush)
epc_out  out  32  current EPC, with same-cycle mtc0 to EPC forwarded
exl  out  1  SR.EXL, for observation

Behaviour:
- Registers: SR(12): IM=[15:10], EXL=[1], IE=[0]; other bits read 0. Cause(13): BD=[31], IP=[15:10], ExcCode=[6:2]; other bits read 0. EPC(14): 32 bits. PRId(15): PARAMETER constant.
- Reset (async, reset_n=0): SR=0, Cause=0, EPC=0; req=0, epc_out=0, exl=0, rdata=0 for any address except 15.
- Interrupt request: int_req = |(hw_int & SR.IM) & SR.IE & ~SR.EXL.
- Exception request: exc_req = (exc_code_m != 0) & ~SR.EXL.
- req = int_req | exc_req, combinational, same cycle.
- Interrupt takes priority over a simultaneous exception. ExcCode is 0 for an interrupt and exc_code_m otherwise.
- At the clock edge where req=1:
  - EXL <= 1
  - Cause.BD <= bd_m
  - Cause.ExcCode <= chosen code
  - EPC <= bd_m ? pc_m-4 : pc_m, with bits [1:0] forced to 0
  - any mtc0 that cycle is suppressed, because the faulting instruction is cancelled.
- Cause.IP <= hw_int every cycle, independent of EXL, req and writes. It is read-only to mtc0.
- eret_m=1 with req=0: EXL <= 0 at the edge. eret with req=1 is ignored, because req wins.
- mtc0 with we=1 and req=0:
  - reg 12 writes IM/EXL/IE
  - reg 14 writes EPC (full 32 bits)
  - reg 13 and reg 15 writes are ignored
  - other addresses are no-ops.
- epc_out = (we & reg_addr==14 & ~req) ? wdata : EPC. This forwarding covers mtc0 EPC immediately followed by eret.
- rdata is combinational from reg_addr, returning pre-edge register values. Unimplemented addresses return 0.
- Latency: req has 0-cycle latency from its inputs. State updates take 1 cycle. An interrupt request masked by EXL stays pending in IP and fires in the cycle after eret clears EXL, if IE and IM are still set.
- Reset asserted mid-exception clears EXL immediately. req deasserts asynchronously, since SR.IE=0.

Decomposition:
- Shared package/header:
  - CP0 register numbers (12/13/14/15)
  - SR/Cause bit-field positions
  - ExcCode values (Int=0, AdEL=4, AdES=5, RI=10, Ov=12)
  - HANDLER_PC constant
- No sub-module. The block is one register file plus request logic; an optional cp0_req_logic is not warranted.

Test Plan:
- Reset then read: reset_n=0 -> rdata=0 for reg12/13/14 and PRID_VALUE for reg15; req=0.
- Interrupt: mtc0 SR=32'h0000_0401 (IM[10]=1, IE=1), then hw_int=6'b000001, pc_m=32'h3010, bd_m=0 -> req=1 that cycle; next cycle EPC=32'h3010, Cause=32'h0000_0400, EXL=1, req=0.
- Delay-slot exception: exc_code_m=12 (Ov), pc_m=32'h3024, bd_m=1 -> req=1; EPC=32'h3020, Cause.BD=1, ExcCode=12; a simultaneous mtc0 to EPC is dropped.
- eret and pending interrupt: with EXL=1, IE=1 and hw_int held high, pulse eret_m -> EXL=0 next cycle; req=1 the following cycle.
- EPC forwarding: we=1, reg_addr=14, wdata=32'h3100 with req=0 -> epc_out=32'h3100 in the same cycle; EPC=32'h3100 after the edge.
- Simultaneous interrupt and exception: exc_code_m=4 plus an enabled interrupt -> ExcCode=0; an eret_m in the same cycle is ignored and EXL=1 after the edge.
